// File: rtl/conv1d_mac_layer.sv
// LANES-wide, runtime K-tap 1-D convolution: signed MAC per lane, then bias, round-half-up,
// saturate and optional ReLU. One job per cfg_start, valid/ready streams on both sides.
module conv1d_mac_layer #(
   parameter int LANES    = 16,
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 8,
   parameter int TAPS_MAX = 8,
   parameter int ACC_W    = 40
) (
   input  logic                      clk_PL,
   input  logic                      rst,
   input  logic                      cfg_start,
   input  logic [$clog2(TAPS_MAX+1)-1:0] cfg_taps,
   input  logic [DATA_W-1:0]         cfg_bias,
   input  logic                      cfg_relu,
   output logic                      cfg_err,
   output logic                      busy,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic [DATA_W-1:0]         in_weight,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [LANES-1:0]          out_sat
);

   localparam int TW = $clog2(TAPS_MAX + 1);
   localparam int RND_SH = (FRAC_W > 0) ? FRAC_W - 1 : 0;
   localparam logic [ACC_W-1:0] ONE_C = {{(ACC_W-1){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] RND_C = (FRAC_W > 0) ? (ONE_C << RND_SH) : {ACC_W{1'b0}};
   localparam logic signed [ACC_W-1:0] MAX_C = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_C = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   if (ACC_W < 2*DATA_W + $clog2(TAPS_MAX) + 1) begin : g_acc_w_check
      $error("conv1d_mac_layer: ACC_W too narrow for DATA_W/TAPS_MAX");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_OUT} state_t;

   // Full-precision signed product, sign-extended into the accumulator.
   function automatic logic signed [ACC_W-1:0] mac_lane(input logic signed [ACC_W-1:0] acc,
                                                        input logic [DATA_W-1:0] x,
                                                        input logic [DATA_W-1:0] w);
      logic signed [2*DATA_W-1:0] prod;
      prod = $signed(x) * $signed(w);
      return acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   endfunction

   // Returns {sat, result}: bias, round half up, clamp, then ReLU.
   function automatic logic [DATA_W:0] post_proc(input logic signed [ACC_W-1:0] acc,
                                                 input logic [DATA_W-1:0] bias,
                                                 input logic relu);
      logic signed [ACC_W-1:0] s;
      logic [DATA_W-1:0]       r;
      logic                    sat;
      s = acc + ({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W);
      s = s + RND_C;
      s = s >>> FRAC_W;
      if (s > MAX_C) begin
         r   = MAX_C[DATA_W-1:0];
         sat = 1'b1;
      end else if (s < MIN_C) begin
         r   = MIN_C[DATA_W-1:0];
         sat = 1'b1;
      end else begin
         r   = s[DATA_W-1:0];
         sat = 1'b0;
      end
      if (relu && r[DATA_W-1]) begin
         r = {DATA_W{1'b0}};
      end else begin
         r = r;
      end
      return {sat, r};
   endfunction

   state_t                   state_q, state_d;
   logic [TW-1:0]            taps_q, taps_d, cnt_q, cnt_d;
   logic [DATA_W-1:0]        bias_q, bias_d;
   logic                     relu_q, relu_d;
   logic signed [ACC_W-1:0]  acc_q [LANES];
   logic signed [ACC_W-1:0]  acc_d [LANES];
   logic [LANES*DATA_W-1:0]  out_data_q, out_data_d;
   logic [LANES-1:0]         out_sat_q, out_sat_d;
   logic                     out_valid_q, out_valid_d;
   logic                     busy_q, busy_d, in_ready_q, in_ready_d, cfg_err_q, cfg_err_d;
   logic [DATA_W:0]          pp_s;
   logic                     taps_ok_s;

   assign taps_ok_s = (cfg_taps != {TW{1'b0}}) && (cfg_taps <= TW'(TAPS_MAX));

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d     = state_q;
      taps_d      = taps_q;
      bias_d      = bias_q;
      relu_d      = relu_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_valid_d = out_valid_q;
      cfg_err_d   = 1'b0;
      pp_s        = {(DATA_W+1){1'b0}};
      case (state_q)
         S_IDLE: begin
            if (cfg_start && taps_ok_s) begin
               taps_d  = cfg_taps;
               bias_d  = cfg_bias;
               relu_d  = cfg_relu;
               cnt_d   = {TW{1'b0}};
               for (int i = 0; i < LANES; i++) acc_d[i] = {ACC_W{1'b0}};
               state_d = S_ACCUM;
            end else if (cfg_start) begin
               cfg_err_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               for (int i = 0; i < LANES; i++)
                  acc_d[i] = mac_lane(acc_q[i], in_data[i*DATA_W +: DATA_W], in_weight);
               cnt_d = cnt_q + TW'(1);
               if (cnt_d == taps_q) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_ACCUM;
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_FINISH: begin
            for (int i = 0; i < LANES; i++) begin
               pp_s = post_proc(acc_q[i], bias_q, relu_q);
               out_data_d[i*DATA_W +: DATA_W] = pp_s[DATA_W-1:0];
               out_sat_d[i] = pp_s[DATA_W];
            end
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      busy_d     = (state_d != S_IDLE);
      in_ready_d = (state_d == S_ACCUM);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_PL) begin
      if (rst) begin
         state_q     <= S_IDLE;
         taps_q      <= {TW{1'b0}};
         bias_q      <= {DATA_W{1'b0}};
         relu_q      <= 1'b0;
         cnt_q       <= {TW{1'b0}};
         for (int i = 0; i < LANES; i++) acc_q[i] <= {ACC_W{1'b0}};
         out_data_q  <= {(LANES*DATA_W){1'b0}};
         out_sat_q   <= {LANES{1'b0}};
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         taps_q      <= taps_d;
         bias_q      <= bias_d;
         relu_q      <= relu_d;
         cnt_q       <= cnt_d;
         for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign in_ready  = in_ready_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv1d_mac_layer.sv
// Directed bench for conv1d_mac_layer: integer reference model plus hand-computed literals.
module tb_conv1d_mac_layer;
   localparam int LANES = 16, DATA_W = 16, FRAC_W = 8, TAPS_MAX = 8, ACC_W = 40;
   localparam int VW = LANES * DATA_W;

   logic clk_PL = 1'b0, rst = 1'b1;
   logic cfg_start = 1'b0, cfg_relu = 1'b0;
   logic [3:0] cfg_taps = 4'd0;
   logic [DATA_W-1:0] cfg_bias = '0, in_weight = '0;
   logic cfg_err, busy, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [VW-1:0] in_data = '0, out_data;
   logic [LANES-1:0] out_sat;

   conv1d_mac_layer #(.LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W),
                      .TAPS_MAX(TAPS_MAX), .ACC_W(ACC_W)) dut (
      .clk_PL(clk_PL), .rst(rst), .cfg_start(cfg_start), .cfg_taps(cfg_taps),
      .cfg_bias(cfg_bias), .cfg_relu(cfg_relu), .cfg_err(cfg_err), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat));

   always #5 clk_PL = ~clk_PL;

   int checks = 0, failures = 0;
   longint m_acc [LANES];
   longint m_bias;
   bit m_relu;
   logic [VW-1:0] exp_data;
   logic [LANES-1:0] exp_sat;
   bit exp_valid = 1'b0;
   logic [VW-1:0] lit;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Compare outputs against the model whenever a result is presented.
   always @(negedge clk_PL) begin
      if (out_valid) begin
         if (exp_valid) begin
            chk("out_data", out_data, exp_data);
            chk("out_sat", {{(VW-LANES){1'b0}}, out_sat}, {{(VW-LANES){1'b0}}, exp_sat});
         end else begin
            chk("spurious_out_valid", {{(VW-1){1'b0}}, out_valid}, '0);
         end
      end
   end

   task automatic tick();
      @(posedge clk_PL);
      #1;
   endtask

   task automatic start_job(input int taps, input int bias, input bit relu);
      cfg_taps = 4'(taps); cfg_bias = 16'(bias); cfg_relu = relu; cfg_start = 1'b1;
      for (int i = 0; i < LANES; i++) m_acc[i] = 0;
      m_bias = longint'($signed(16'(bias)));
      m_relu = relu;
      tick();
      cfg_start = 1'b0;
      chk("busy_after_start", {{(VW-1){1'b0}}, busy}, 1);
   endtask

   task automatic beat(input logic [VW-1:0] d, input logic [DATA_W-1:0] w, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) tick();
      chk("busy_in_job", {{(VW-1){1'b0}}, busy}, 1);
      in_data = d; in_weight = w; in_valid = 1'b1; n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", {{(VW-1){1'b0}}, in_ready}, 1);
      end else begin
         tick();
         for (int i = 0; i < LANES; i++)
            m_acc[i] += longint'($signed(d[i*DATA_W +: DATA_W])) * longint'($signed(w));
      end
      in_valid = 1'b0;
   endtask

   task automatic model_result();
      longint s, scale;
      scale = longint'(1) <<< FRAC_W;
      for (int i = 0; i < LANES; i++) begin
         s = m_acc[i] + m_bias * scale;
         if (FRAC_W > 0) s += scale / 2;
         s = s >>> FRAC_W;
         exp_sat[i] = (s > 32767) || (s < -32768);
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         if (m_relu && s < 0) s = 0;
         exp_data[i*DATA_W +: DATA_W] = 16'(s);
      end
   endtask

   task automatic finish_job(input int hold, input bit probe);
      model_result();
      exp_valid = 1'b1;
      chk("out_valid_not_yet", {{(VW-1){1'b0}}, out_valid}, 0);
      tick();
      chk("out_valid_latency", {{(VW-1){1'b0}}, out_valid}, 1);
      chk("in_ready_in_out", {{(VW-1){1'b0}}, in_ready}, 0);
      for (int c = 0; c < hold; c++) begin
         if (probe) begin
            cfg_start = 1'b1;
            cfg_taps = c[0] ? 4'd9 : 4'd2;
         end
         tick();
         cfg_start = 1'b0;
         chk("hold_out_valid", {{(VW-1){1'b0}}, out_valid}, 1);
         chk("hold_in_ready", {{(VW-1){1'b0}}, in_ready}, 0);
         chk("hold_cfg_err", {{(VW-1){1'b0}}, cfg_err}, 0);
         chk("hold_busy", {{(VW-1){1'b0}}, busy}, 1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_valid = 1'b0;
      chk("out_valid_cleared", {{(VW-1){1'b0}}, out_valid}, 0);
      chk("busy_cleared", {{(VW-1){1'b0}}, busy}, 0);
   endtask

   task automatic bad_cfg(input int taps);
      cfg_taps = 4'(taps); cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("cfg_err_pulse", {{(VW-1){1'b0}}, cfg_err}, 1);
      chk("cfg_err_busy", {{(VW-1){1'b0}}, busy}, 0);
      tick();
      chk("cfg_err_one_cycle", {{(VW-1){1'b0}}, cfg_err}, 0);
      chk("cfg_err_stay_idle", {{(VW-1){1'b0}}, busy}, 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_out_data", out_data, '0);
      chk("rst_flags", {{(VW-6){1'b0}}, (|out_sat), out_valid, busy, in_ready, cfg_err, 1'b0}, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) tick();
      chk_reset_outputs();
      rst = 1'b0;
      tick();

      // Single tap: lane i = i*0x0100, weight 0x0200 -> i*0x0200
      for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = 16'(i * 256);
      start_job(1, 0, 1'b0);
      beat(in_data, 16'h0200, 0);
      finish_job(0, 1'b0);
      for (int i = 0; i < LANES; i++) lit[i*DATA_W +: DATA_W] = 16'(i * 512);
      chk("lit_single_tap_retained", out_data, lit);

      // Three taps with bias and gaps -> 0x0280
      start_job(3, 16'h0080, 1'b0);
      beat({LANES{16'h0400}}, 16'h0100, 2);
      beat({LANES{16'h0400}}, 16'h0080, 2);
      beat({LANES{16'h0400}}, 16'hFF00, 2);
      finish_job(0, 1'b0);
      chk("lit_multi_tap", out_data, {LANES{16'h0280}});

      // ReLU on and off
      start_job(1, 0, 1'b1);
      beat({LANES{16'h0300}}, 16'hFF00, 0);
      finish_job(0, 1'b0);
      chk("lit_relu_on", out_data, '0);
      start_job(1, 0, 1'b0);
      beat({LANES{16'h0300}}, 16'hFF00, 1);
      finish_job(0, 1'b0);
      chk("lit_relu_off", out_data, {LANES{16'hFD00}});

      // Saturation both directions
      start_job(8, 0, 1'b0);
      for (int t = 0; t < 8; t++) beat({LANES{16'h7FFF}}, 16'h7FFF, 0);
      finish_job(0, 1'b0);
      chk("lit_sat_pos", out_data, {LANES{16'h7FFF}});
      chk("lit_sat_pos_flag", {{(VW-LANES){1'b0}}, out_sat}, {{(VW-LANES){1'b0}}, 16'hFFFF});
      start_job(8, 0, 1'b0);
      for (int t = 0; t < 8; t++) beat({LANES{16'h7FFF}}, 16'h8000, 0);
      finish_job(0, 1'b0);
      chk("lit_sat_neg", out_data, {LANES{16'h8000}});
      chk("lit_sat_neg_flag", {{(VW-LANES){1'b0}}, out_sat}, {{(VW-LANES){1'b0}}, 16'hFFFF});

      // Backpressure with ignored starts during OUT
      start_job(2, 16'hFFF0, 1'b0);
      beat({LANES{16'h1234}}, 16'h0033, 0);
      beat({LANES{16'hF00D}}, 16'h0101, 3);
      finish_job(5, 1'b1);

      // Illegal tap counts
      bad_cfg(0);
      bad_cfg(9);

      // Reset mid-job, then a fresh single-tap job
      start_job(4, 0, 1'b0);
      beat({LANES{16'h0100}}, 16'h0100, 0);
      beat({LANES{16'h0100}}, 16'h0100, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_outputs();
      tick();
      chk("no_output_after_abort", {{(VW-1){1'b0}}, out_valid}, 0);
      start_job(1, 0, 1'b0);
      beat({LANES{16'h0100}}, 16'h0100, 0);
      finish_job(0, 1'b0);
      chk("lit_after_reset", out_data, {LANES{16'h0100}});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv1d_mac_layer.md
Name: conv1d_mac_layer

Overview:
Parametrised successor to the fixed 16-lane multiply/bias/ReLU conv layer. It computes a LANES-wide, K-tap 1-D convolution output vector using signed fixed-point multiply-accumulate over a runtime-configured number of taps, then adds bias, rounds, saturates and applies optional ReLU. Valid/ready streams sit on both sides, and a one-shot config interface starts each job. It sits between the line-buffer feeder and the pooling stage.

Parameters:
LANES, 16, parallel output channels/pixels per beat
DATA_W, 16, signed sample/weight/bias/output width
FRAC_W, 8, fractional bits of the Q format (0 allowed)
TAPS_MAX, 8, maximum taps per job
ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(TAPS_MAX) + 1 (elaboration error otherwise)

Ports:
clk_PL  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
cfg_start  in  1  start-job pulse, honoured only in IDLE
cfg_taps  in  clog2(TAPS_MAX+1)  taps for this job, valid range 1..TAPS_MAX
cfg_bias  in  DATA_W  signed bias in Q format
cfg_relu  in  1  1 = apply ReLU to the output
cfg_err  out  1  one-cycle pulse when cfg_start arrives in IDLE with illegal cfg_taps
busy  out  1  high from the cycle after an accepted start until the output handshake completes
in_valid  in  1  tap beat valid
in_ready  out  1  high only in ACCUM
in_data  in  LANES*DATA_W  signed samples; lane i = bits [i*DATA_W +: DATA_W]
in_weight  in  DATA_W  signed weight shared by all lanes for this tap
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  LANES*DATA_W  result, same lane packing as in_data
out_sat  out  LANES  per-lane flag: saturation occurred

Behaviour:
- Clock/reset: one clock, clk_PL; reset rst is synchronous and active-high. On reset the state goes to IDLE, and accumulators, tap counter and all outputs (out_data, out_sat, out_valid, busy, cfg_err, in_ready) go to 0. Reset mid-job abandons the partial sum with no output.
- FSM: IDLE -> ACCUM -> FINISH -> OUT -> IDLE.
- IDLE: in_ready=0.
  - cfg_start with cfg_taps in 1..TAPS_MAX: latch taps/bias/relu, clear accumulators and tap counter, go to ACCUM.
  - cfg_start with an illegal cfg_taps: cfg_err=1 for exactly one cycle and stay in IDLE.
  - cfg_start in any other state: ignored, no cfg_err.
- ACCUM: in_ready=1. On each in_valid&&in_ready edge: acc[i] += sext(in_data[i]) * sext(in_weight), with the full 2*DATA_W signed product sign-extended to ACC_W, and the tap counter increments. The handshake on beat number taps moves to FINISH. Idle cycles (in_valid=0) have no effect.
- FINISH (exactly 1 cycle), in_ready=0:
  - s = acc + (sext(bias) << FRAC_W)
  - if FRAC_W>0: s += 1 << (FRAC_W-1), then arithmetic shift right by FRAC_W (round half up)
  - clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat[i] = clamp applied
  - if cfg_relu and result < 0: result = 0 (out_sat unaffected)
  - register into out_data/out_sat and set out_valid=1; go to OUT.
- Latency: the last beat is accepted at edge k; out_valid is high from edge k+1.
- OUT: out_data/out_sat/out_valid held stable while out_ready=0. On out_valid&&out_ready: out_valid=0, busy=0, go to IDLE. The next cfg_start is honoured from the following cycle, so there is a minimum 1-cycle gap between jobs.
- Reset priority: rst overrides every simultaneous event, including handshakes.
- Retention: out_data retains its last value after the handshake; it changes only in FINISH or on reset.

Test Plan:
Common setup for all scenarios: LANES=16, DATA_W=16, FRAC_W=8.
- Single tap: taps=1, bias=0, weight=0x0200, lane i=i*0x0100 -> lane i out=i*0x0200, out_sat=0, out_valid exactly 1 edge after the beat.
- Multi-tap with bias: taps=3, weights 0x0100, 0x0080, 0xFF00, all lanes 0x0400, bias=0x0080, in_valid gaps of 2 cycles -> all lanes 0x0280, busy high throughout.
- ReLU mode: taps=1, weight=0xFF00, input 0x0300, bias=0: cfg_relu=1 -> 0x0000; cfg_relu=0 -> 0xFD00.
- Saturation: taps=8, all inputs 0x7FFF, weight 0x7FFF -> 0x7FFF, out_sat=16'hFFFF. Repeat with weight 0x8000 and relu=0 -> 0x8000, out_sat=16'hFFFF.
- Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0, cfg_start ignored with no cfg_err; raise out_ready -> IDLE next edge.
- Config/reset:
  - cfg_taps=0 and cfg_taps=9 -> one-cycle cfg_err, busy stays 0.
  - rst after 2 of 4 beats -> all outputs 0; a new taps=1 job (weight 0x0100, input 0x0100) yields exactly 0x0100.
